// File: rtl/prio_arbiter_4.sv
// 4-requester arbiter: index 3 wins by default, grants are held until release or MAX_HOLD, with one dead cycle between owners.
// Define PRIO_ARB_ROUND_ROBIN_EN to rotate priority, starting below the last owner.
module prio_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       expired
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t     state_q;
  logic [3:0] gnt_q;
  logic [1:0] gnt_id_q;
  logic       busy_q;
  logic       expired_q;
  logic [7:0] hold_q;
  logic [1:0] last_owner_q;
  logic [3:0] mask_q;

  logic [3:0] elig_d;
  logic [1:0] win_d;
  logic [7:0] hold_d;
  logic       hold_last_d;

  assign elig_d      = req & ~mask_q;
  assign hold_d      = hold_q + 8'd1;
  assign hold_last_d = (hold_q == 8'(MAX_HOLD - 1));

  // The loop runs from lowest to highest priority, so the last hit is the winner.
  always_comb begin
    win_d = 2'd0;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
    for (int i = 4; i >= 1; i--) begin
      if (elig_d[last_owner_q - 2'(i)]) win_d = last_owner_q - 2'(i);
    end
`else
    for (int i = 0; i < 4; i++) begin
      if (elig_d[i]) win_d = 2'(i);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_q        <= 4'b0000;
      gnt_id_q     <= 2'd0;
      busy_q       <= 1'b0;
      expired_q    <= 1'b0;
      hold_q       <= 8'd0;
      last_owner_q <= 2'd0;
      mask_q       <= 4'b0000;
    end else begin
      expired_q <= 1'b0;
      case (state_q)
        IDLE, GAP: begin
          if (en && (elig_d != 4'b0000)) begin
            state_q      <= GRANT;
            gnt_q        <= 4'b0001 << win_d;
            gnt_id_q     <= win_d;
            last_owner_q <= win_d;
            busy_q       <= 1'b1;
            hold_q       <= 8'd0;
            mask_q       <= 4'b0000;
          end else begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            busy_q  <= 1'b0;
            mask_q  <= 4'b0000;
          end
        end
        GRANT: begin
          if (!en) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            busy_q  <= 1'b0;
          end else if (!req[last_owner_q]) begin
            state_q <= GAP;
            gnt_q   <= 4'b0000;
            busy_q  <= 1'b0;
          end else if (hold_last_d) begin
            // The expired owner sits out the arbitration made in GAP.
            state_q   <= GAP;
            gnt_q     <= 4'b0000;
            busy_q    <= 1'b0;
            expired_q <= 1'b1;
            mask_q    <= gnt_q;
          end else begin
            hold_q <= hold_d;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 4'b0000;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = busy_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_prio_arbiter_4.sv
// Directed bench for prio_arbiter_4 (MAX_HOLD=4); expected outputs are queued per cycle and compared after each edge.
module tb_prio_arbiter_4;

`ifdef PRIO_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       expired;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       en;
    logic [3:0] req;
    logic [7:0] exp;
  } step_t;

  logic [7:0] sb_q[$];

  prio_arbiter_4 #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .expired(expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Packs {gnt, gnt_id, busy, expired}.
  function automatic logic [7:0] ex(input logic [3:0] g, input logic [1:0] id,
                                    input logic b, input logic x);
    return {g, id, b, x};
  endfunction

  function automatic logic [3:0] oh(input logic [1:0] k);
    return 4'b0001 << k;
  endfunction

  task automatic test_reset();
    logic [7:0] got, want;
    rst_n = 1'b0; en = 1'b1; req = 4'b1111;
    #2;
    sb_q.push_back(ex(4'b0000, 2'd0, 1'b0, 1'b0));
    got = {gnt, gnt_id, busy, expired}; want = sb_q.pop_front();
    tests++;
    if (got !== want) begin
      fails++; $display("FAIL reset_initial: got %b want %b", got, want);
    end
    sb_q.push_back(ex(4'b0000, 2'd0, 1'b0, 1'b0));
    @(posedge clk); #1;
    got = {gnt, gnt_id, busy, expired}; want = sb_q.pop_front();
    tests++;
    if (got !== want) begin
      fails++; $display("FAIL reset_held_edge: got %b want %b", got, want);
    end
    rst_n = 1'b1; req = 4'b0000;
    sb_q.push_back(ex(4'b0000, 2'd0, 1'b0, 1'b0));
    @(posedge clk); #1;
    got = {gnt, gnt_id, busy, expired}; want = sb_q.pop_front();
    tests++;
    if (got !== want) begin
      fails++; $display("FAIL reset_idle: got %b want %b", got, want);
    end
  endtask

  task automatic test_basic();
    step_t s[$];
    logic [7:0] got, want;
    s.push_back('{1'b1, 4'b0101, ex(4'b0100, 2'd2, 1'b1, 1'b0)});
    s.push_back('{1'b1, 4'b0001, ex(4'b0000, 2'd2, 1'b0, 1'b0)});
    s.push_back('{1'b1, 4'b0001, ex(4'b0001, 2'd0, 1'b1, 1'b0)});
    s.push_back('{1'b1, 4'b0000, ex(4'b0000, 2'd0, 1'b0, 1'b0)});
    s.push_back('{1'b1, 4'b0000, ex(4'b0000, 2'd0, 1'b0, 1'b0)});
    foreach (s[i]) begin
      en = s[i].en; req = s[i].req; sb_q.push_back(s[i].exp);
      @(posedge clk); #1;
      got = {gnt, gnt_id, busy, expired}; want = sb_q.pop_front();
      tests++;
      if (got !== want) begin
        fails++; $display("FAIL basic[%0d]: got %b want %b", i, got, want);
      end
    end
  endtask

  task automatic test_priority();
    step_t s[$];
    logic [7:0] got, want;
    s.push_back('{1'b1, 4'b1111, ex(4'b1000, 2'd3, 1'b1, 1'b0)});
    s.push_back('{1'b1, 4'b0111, ex(4'b0000, 2'd3, 1'b0, 1'b0)});
    s.push_back('{1'b1, 4'b0111, ex(4'b0100, 2'd2, 1'b1, 1'b0)});
    s.push_back('{1'b1, 4'b0011, ex(4'b0000, 2'd2, 1'b0, 1'b0)});
    s.push_back('{1'b1, 4'b0011, ex(4'b0010, 2'd1, 1'b1, 1'b0)});
    s.push_back('{1'b1, 4'b0001, ex(4'b0000, 2'd1, 1'b0, 1'b0)});
    s.push_back('{1'b1, 4'b0001, ex(4'b0001, 2'd0, 1'b1, 1'b0)});
    s.push_back('{1'b1, 4'b0000, ex(4'b0000, 2'd0, 1'b0, 1'b0)});
    s.push_back('{1'b1, 4'b0000, ex(4'b0000, 2'd0, 1'b0, 1'b0)});
    foreach (s[i]) begin
      en = s[i].en; req = s[i].req; sb_q.push_back(s[i].exp);
      @(posedge clk); #1;
      got = {gnt, gnt_id, busy, expired}; want = sb_q.pop_front();
      tests++;
      if (got !== want) begin
        fails++; $display("FAIL priority[%0d]: got %b want %b", i, got, want);
      end
    end
  endtask

  task automatic test_hold_limit();
    step_t s[$];
    logic [7:0] got, want;
    for (int c = 0; c < 4; c++) s.push_back('{1'b1, 4'b0010, ex(4'b0010, 2'd1, 1'b1, 1'b0)});
    s.push_back('{1'b1, 4'b0010, ex(4'b0000, 2'd1, 1'b0, 1'b1)});
    s.push_back('{1'b1, 4'b0010, ex(4'b0000, 2'd1, 1'b0, 1'b0)});
    s.push_back('{1'b1, 4'b0010, ex(4'b0010, 2'd1, 1'b1, 1'b0)});
    s.push_back('{1'b1, 4'b0000, ex(4'b0000, 2'd1, 1'b0, 1'b0)});
    s.push_back('{1'b1, 4'b0000, ex(4'b0000, 2'd1, 1'b0, 1'b0)});
    foreach (s[i]) begin
      en = s[i].en; req = s[i].req; sb_q.push_back(s[i].exp);
      @(posedge clk); #1;
      got = {gnt, gnt_id, busy, expired}; want = sb_q.pop_front();
      tests++;
      if (got !== want) begin
        fails++; $display("FAIL hold_limit[%0d]: got %b want %b", i, got, want);
      end
    end
  endtask

  task automatic test_enable();
    step_t s[$];
    logic [7:0] got, want;
    logic [1:0] k;
    k = RR ? 2'd0 : 2'd3;
    s.push_back('{1'b0, 4'b1111, ex(4'b0000, 2'd1, 1'b0, 1'b0)});
    s.push_back('{1'b0, 4'b1111, ex(4'b0000, 2'd1, 1'b0, 1'b0)});
    s.push_back('{1'b1, 4'b1111, ex(oh(k), k, 1'b1, 1'b0)});
    s.push_back('{1'b0, 4'b1111, ex(4'b0000, k, 1'b0, 1'b0)});
    s.push_back('{1'b0, 4'b0000, ex(4'b0000, k, 1'b0, 1'b0)});
    s.push_back('{1'b1, 4'b0000, ex(4'b0000, k, 1'b0, 1'b0)});
    foreach (s[i]) begin
      en = s[i].en; req = s[i].req; sb_q.push_back(s[i].exp);
      @(posedge clk); #1;
      got = {gnt, gnt_id, busy, expired}; want = sb_q.pop_front();
      tests++;
      if (got !== want) begin
        fails++; $display("FAIL enable[%0d]: got %b want %b", i, got, want);
      end
    end
  endtask

  task automatic test_async_reset();
    step_t s[$];
    logic [7:0] got, want;
    s.push_back('{1'b1, 4'b1111, ex(4'b1000, 2'd3, 1'b1, 1'b0)});
    s.push_back('{1'b1, 4'b1111, ex(4'b1000, 2'd3, 1'b1, 1'b0)});
    foreach (s[i]) begin
      en = s[i].en; req = s[i].req; sb_q.push_back(s[i].exp);
      @(posedge clk); #1;
      got = {gnt, gnt_id, busy, expired}; want = sb_q.pop_front();
      tests++;
      if (got !== want) begin
        fails++; $display("FAIL async_pre[%0d]: got %b want %b", i, got, want);
      end
    end
    #2;
    rst_n = 1'b0;
    req = 4'b0001;
    sb_q.push_back(ex(4'b0000, 2'd0, 1'b0, 1'b0));
    #1;
    got = {gnt, gnt_id, busy, expired}; want = sb_q.pop_front();
    tests++;
    if (got !== want) begin
      fails++; $display("FAIL async_no_edge: got %b want %b", got, want);
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    s.delete();
    s.push_back('{1'b1, 4'b0001, ex(4'b0001, 2'd0, 1'b1, 1'b0)});
    s.push_back('{1'b1, 4'b0000, ex(4'b0000, 2'd0, 1'b0, 1'b0)});
    s.push_back('{1'b1, 4'b0000, ex(4'b0000, 2'd0, 1'b0, 1'b0)});
    foreach (s[i]) begin
      en = s[i].en; req = s[i].req; sb_q.push_back(s[i].exp);
      @(posedge clk); #1;
      got = {gnt, gnt_id, busy, expired}; want = sb_q.pop_front();
      tests++;
      if (got !== want) begin
        fails++; $display("FAIL async_post[%0d]: got %b want %b", i, got, want);
      end
    end
  endtask

  // All four request continuously; each owner expires and is masked for one arbitration.
  task automatic test_back_to_back();
    step_t s[$];
    logic [7:0] got, want;
    logic [1:0] owners[5];
    if (RR) owners = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
    else    owners = '{2'd3, 2'd2, 2'd3, 2'd2, 2'd3};
    for (int o = 0; o < 5; o++) begin
      for (int c = 0; c < 4; c++)
        s.push_back('{1'b1, 4'b1111, ex(oh(owners[o]), owners[o], 1'b1, 1'b0)});
      s.push_back('{1'b1, 4'b1111, ex(4'b0000, owners[o], 1'b0, 1'b1)});
    end
    s.push_back('{1'b1, 4'b0000, ex(4'b0000, 2'd3, 1'b0, 1'b0)});
    foreach (s[i]) begin
      en = s[i].en; req = s[i].req; sb_q.push_back(s[i].exp);
      @(posedge clk); #1;
      got = {gnt, gnt_id, busy, expired}; want = sb_q.pop_front();
      tests++;
      if (got !== want) begin
        fails++; $display("FAIL back_to_back[%0d]: got %b want %b", i, got, want);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 4'b0000;
    test_reset();
    test_basic();
    test_priority();
    test_hold_limit();
    test_enable();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prio_arbiter_4.md
# prio_arbiter_4

Sequential 4-requester arbiter built around the 4x2 priority encoding rule: input 3 has the highest priority, input 0 the lowest. It grants one requester at a time, holds the grant until the requester releases it or a hold limit expires, and inserts a one-cycle gap between owners. It shares a single downstream resource, such as a bus or a datapath port, among four agents.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per ownership. Legal range is 1..255; the hold counter is 8 bits.
- `clk` in 1: clock. All state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: arbiter enable, analogous to encoder enable `e`. When low, no grants are issued.
- `req` in 4: request vector. Bit i is held high by requester i for as long as it wants ownership.
- `gnt` out 4: one-hot grant, registered. All zeros when no owner.
- `gnt_id` out 2: encoded index of the current or last owner, registered.
- `busy` out 1: high while in state GRANT.
- `expired` out 1: one-cycle pulse when an ownership is force-ended by `MAX_HOLD`.

## Operation
- **Reset values:** state IDLE, `gnt`=0000, `gnt_id`=00, `busy`=0, `expired`=0, hold counter 0, `last_owner`=0, `mask`=0000.
- **States:** IDLE, GRANT, GAP.
- **Arbitration (in IDLE and GAP):**
  - Eligible set = `req` & ~`mask`.
  - If `en` and the eligible set is nonzero, the winner k is chosen per the priority rule (see Configuration).
  - Next state GRANT; `gnt`←one-hot(k), `gnt_id`←k, `last_owner`←k, hold counter←0, `mask`←0.
  - Otherwise the next state is IDLE and `mask` is cleared.
- **GRANT, evaluated in this priority order:**
  1. `en`=0 → IDLE, `gnt`←0. No GAP is inserted.
  2. `req[owner]`=0 → GAP, `gnt`←0.
  3. Hold counter = `MAX_HOLD`-1 and `req[owner]`=1 → GAP, `gnt`←0, `expired` pulses for 1 cycle, `mask`←one-hot(owner).
  4. Otherwise, hold counter increments.
- **Ignored requests:** changes to `req` of non-owners during GRANT are ignored, and no preemption occurs.
- **`gnt_id` between owners:** retains the last owner while IDLE or in GAP.
- **Masking:** the mask blocks the expired requester for exactly one arbitration, in GAP. If it is the only requester, GAP goes to IDLE with no grant, and IDLE grants it on the following cycle.

## Timing
- **Grant latency:** `req` high at edge N in IDLE → `gnt` valid after edge N, i.e. 1 cycle.
- **Release:** `req[owner]` low at edge N → `gnt`=0 after edge N, with GAP for that cycle.
  - If another requester is eligible at edge N+1, its `gnt` is high after N+1.
  - Minimum dead time between owners is 1 cycle.
- **Hold limit:** an owner granted at edge G and holding continuously sees `gnt` drop after edge G+`MAX_HOLD`, i.e. exactly `MAX_HOLD` grant cycles. `expired` is high for the cycle following that edge.
- **`MAX_HOLD`=1:** every ownership lasts 1 cycle and expires if the request persists.
- **Enable:** `en` low at any edge clears `gnt` and `busy` after that edge. `gnt_id` is unchanged.
- **Mid-operation reset:** asserting `rst_n` low clears all outputs immediately, without waiting for a clock edge. On release, the first arbitration occurs at the first rising edge with `rst_n` high.
- **One-hot invariant:** `gnt` is always one-hot or zero, and is never asserted in GAP or IDLE.

## Configuration
- **Macro:** `PRIO_ARB_ROUND_ROBIN_EN`.
- **Undefined:** fixed priority, index 3 > 2 > 1 > 0, identical to the 4x2 priority encoder ordering.
- **Defined:** rotating priority.
  - Highest priority goes to (`last_owner`-1) mod 4, then descends mod 4.
  - Since `last_owner` resets to 0, the first arbitration after reset is identical to fixed priority.
  - `last_owner` updates on every grant.

## Test plan
- **Basic grant:** reset, `en`=1, `req`=0101 → `gnt`=0100, `gnt_id`=10 one cycle later. Drop `req[2]` → `gnt`=0000 for the GAP cycle, then `gnt`=0001, `gnt_id`=00.
- **Priority:** `req`=1111 in fixed mode → `gnt`=1000. Release bit 3 while the others stay high → next owner 0100, then 0010, then 0001.
- **Hold limit:** `MAX_HOLD`=4, `req`=0010 held → `gnt`=0010 for 4 cycles, then `expired`=1 and `gnt`=0000 in GAP. The next cycle is IDLE, and `gnt`=0010 is regranted one cycle later.
- **Enable:** `en`=0 with `req`=1111 → `gnt` stays 0000 and `busy`=0. Deassert `en` during GRANT → `gnt`=0000 after the next edge, and `gnt_id` is unchanged.
- **Round robin** (macro defined): `req`=1111 held with `MAX_HOLD`=2 → owners 3, 2, 1, 0, 3 in order, each for 2 cycles, separated by GAP cycles with `expired` pulses.
- **Async reset:** pull `rst_n` low mid-grant, between clock edges → `gnt`=0000, `busy`=0, `gnt_id`=00 without a clock edge. After release, `req`=0001 → `gnt`=0001 after the first edge.
